hdlc_tx_framer: RTL

HDLC_TX_FRAMER -- requirements
Module: hdlc_tx_framer

---
 rtl/hdlc_pkg.sv | 26 ++
 rtl/hdlc_tx_stuffer.sv | 74 +++++++
 rtl/hdlc_tx_framer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/hdlc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hdlc_pkg
// Description : Shared types and constants for the HDLC transmit framer.
// Revision    : 1.0 - initial release
// ============================================================================
package hdlc_pkg;

  // Framer state encoding
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START_FLAG = 3'd1,
    ST_DATA       = 3'd2,
    ST_END_FLAG   = 3'd3,
    ST_ABORT      = 3'd4
  } tx_state_e;

  // Opening/closing flag, sent LSB first, never stuffed
  localparam logic [7:0] FLAG = 8'h7E;
  // Abort sequence: a 0 followed by seven 1s when sent LSB first
  localparam logic [7:0] ABORT_PAT = 8'hFE;
  // Number of consecutive data ones that forces an inserted 0
  localparam int unsigned STUFF_LIMIT = 5;

endpackage
`default_nettype wire

// File: rtl/hdlc_tx_stuffer.sv
`default_nettype none
// ============================================================================
// Module      : hdlc_tx_stuffer
// Description : Payload bit shifter with zero-insertion ones counter. Presents
//               the current data bit, an insert-zero strobe and a need-byte
//               strobe marking the last bit slot of the current byte.
// Revision    : 1.0 - initial release
// ============================================================================
module hdlc_tx_stuffer
  import hdlc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       advance_i,    // one data bit slot is consumed this cycle
  input  logic       load_i,       // a new byte is accepted this cycle
  input  logic       clr_ones_i,   // frame enters the data phase
  input  logic [7:0] data_i,
  output logic       data_bit_o,
  output logic       insert_zero_o,
  output logic       need_byte_o
);

  logic [7:0] shift_q, shift_d;
  // Bits of the current byte already sent; 8 means only a stuffed 0 remains
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] ones_q, ones_d;
  logic       ones_full_next;

  assign insert_zero_o  = (ones_q == 3'(STUFF_LIMIT));
  assign ones_full_next = shift_q[0] && (ones_q == 3'(STUFF_LIMIT - 1));
  assign data_bit_o     = shift_q[0];
  // The byte is exhausted on its last bit, unless that bit forces a stuffed 0,
  // in which case the stuffed slot becomes the last slot of the byte.
  assign need_byte_o    = insert_zero_o ? (cnt_q == 4'd8)
                                        : ((cnt_q == 4'd7) && !ones_full_next);

  // Next-state for shifter, bit count and ones counter
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    if (advance_i) begin
      if (insert_zero_o) begin
        ones_d = '0;
      end else begin
        shift_d = {1'b0, shift_q[7:1]};
        cnt_d   = cnt_q + 4'd1;
        ones_d  = shift_q[0] ? ones_q + 3'd1 : 3'd0;
      end
    end
    if (load_i) begin
      shift_d = data_i;
      cnt_d   = '0;
    end
    if (clr_ones_i) begin
      ones_d = '0;
    end
  end

  // Shifter state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
      ones_q  <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hdlc_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : hdlc_tx_framer
// Description : HDLC transmit framer. Wraps payload bytes in flags, performs
//               zero insertion, and aborts on request, underrun or overlength.
// Revision    : 1.0 - initial release
// ============================================================================
module hdlc_tx_framer
  import hdlc_pkg::*;
#(
  parameter int MAX_BYTES = 128
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Start,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_DataValid,
  input  logic       Tx_FrameEnd,
  input  logic       Tx_AbortFrame,
  output logic       Tx_DataReady,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_AbortedTrans,
  output logic       Tx_Done
);

  localparam int BCW = $clog2(MAX_BYTES + 1);

  tx_state_e      state_q, state_d;
  logic [2:0]     fcnt_q, fcnt_d;       // bit index within flag / abort pattern
  logic [BCW-1:0] bytes_q, bytes_d;     // payload bytes accepted in this frame
  logic           last_q, last_d;       // the byte in the shifter is the last one
  logic           tx_q, tx_d;
  logic           valid_q, valid_d;
  logic           end_slot_q, end_slot_d;
  logic           abort_slot_q, abort_slot_d;
  logic           done_q, done_d;
  logic           aborted_q, aborted_d;

  logic shift_bit, insert_zero, need_byte;
  logic accept, over_len, load, line_bit;

  assign Tx_DataReady = ((state_q == ST_START_FLAG) && (fcnt_q == 3'd7)) ||
                        ((state_q == ST_DATA) && need_byte && !last_q);
  assign accept       = Tx_DataReady && Tx_DataValid;
  assign over_len     = accept && !Tx_FrameEnd && (bytes_q == BCW'(MAX_BYTES));
  // An abort in the same cycle discards the offered byte
  assign load         = accept && !Tx_AbortFrame && !over_len;

  hdlc_tx_stuffer u_stuffer (
    .clk_i        (Clk),
    .rst_i        (Rst),
    .advance_i    (state_q == ST_DATA),
    .load_i       (load),
    .clr_ones_i   (load && (state_q == ST_START_FLAG)),
    .data_i       (Tx_Data),
    .data_bit_o   (shift_bit),
    .insert_zero_o(insert_zero),
    .need_byte_o  (need_byte)
  );

  // Next-state, line bit selection and pulse staging
  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q + 3'd1;
    bytes_d      = bytes_q;
    last_d       = last_q;
    line_bit     = 1'b1;
    case (state_q)
      ST_IDLE: begin
        fcnt_d = '0;
        if (Tx_Start) begin
          state_d = ST_START_FLAG;
          bytes_d = '0;
          last_d  = 1'b0;
        end
      end
      ST_START_FLAG, ST_DATA: begin
        if (state_q == ST_START_FLAG) begin
          line_bit = FLAG[fcnt_q];
        end else begin
          line_bit = insert_zero ? 1'b0 : shift_bit;
          fcnt_d   = '0;
        end
        if (Tx_AbortFrame) begin
          state_d = ST_ABORT;
          fcnt_d  = '0;
        end else if (Tx_DataReady) begin
          if (!Tx_DataValid || over_len) begin
            state_d = ST_ABORT;
            fcnt_d  = '0;
          end else begin
            state_d = ST_DATA;
            fcnt_d  = '0;
            bytes_d = bytes_q + BCW'(1);
            last_d  = Tx_FrameEnd;
          end
        end else if ((state_q == ST_DATA) && need_byte) begin
          state_d = ST_END_FLAG;
          fcnt_d  = '0;
        end
      end
      ST_END_FLAG: begin
        line_bit = FLAG[fcnt_q];
        if (fcnt_q == 3'd7) state_d = ST_IDLE;
      end
      ST_ABORT: begin
        line_bit = ABORT_PAT[fcnt_q];
        if (fcnt_q == 3'd7) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        fcnt_d  = '0;
      end
    endcase
    tx_d         = line_bit;
    valid_d      = (state_q != ST_IDLE);
    end_slot_d   = (state_q == ST_END_FLAG) && (fcnt_q == 3'd7);
    abort_slot_d = (state_q == ST_ABORT) && (fcnt_q == 3'd7);
    // Pulses land one cycle after the final bit appears on the line
    done_d       = end_slot_q;
    aborted_d    = abort_slot_q;
  end

  // State and registered outputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      fcnt_q       <= '0;
      bytes_q      <= '0;
      last_q       <= 1'b0;
      tx_q         <= 1'b1;
      valid_q      <= 1'b0;
      end_slot_q   <= 1'b0;
      abort_slot_q <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      bytes_q      <= bytes_d;
      last_q       <= last_d;
      tx_q         <= tx_d;
      valid_q      <= valid_d;
      end_slot_q   <= end_slot_d;
      abort_slot_q <= abort_slot_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign Tx              = tx_q;
  assign Tx_ValidFrame   = valid_q;
  assign Tx_Done         = done_q;
  assign Tx_AbortedTrans = aborted_q;

endmodule
`default_nettype wire
